// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard controller: bypass selects and FSM states.
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/forwarding_unit.sv
// Execute-operand bypass select for one source register; the Memory stage wins over Writeback.
module forwarding_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = 4
) (
  input  logic [ADDRESSWIDTH-1:0] rsE,
  input  logic [ADDRESSWIDTH-1:0] rdM,
  input  logic [ADDRESSWIDTH-1:0] rdW,
  input  logic                    regWriteM,
  input  logic                    regWriteW,
  output fwd_sel_t                fwd
);

  always_comb begin
    fwd = FWD_NONE;
    if (regWriteM && (rdM != '0) && (rdM == rsE)) begin
      fwd = FWD_MEM;
    end else if (regWriteW && (rdW != '0) && (rdW == rsE)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/bypass control with a memory-wait watchdog.
// Optional HAZARD_PERF_CNT_EN adds saturating stall and flush cycle counters.
module hazard_controller
  import cpu_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = 4,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNTWIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESSWIDTH-1:0] rs1D,
  input  logic [ADDRESSWIDTH-1:0] rs2D,
  input  logic [ADDRESSWIDTH-1:0] rs1E,
  input  logic [ADDRESSWIDTH-1:0] rs2E,
  input  logic [ADDRESSWIDTH-1:0] rdE,
  input  logic                    memToRegE,
  input  logic                    takeBranchE,
  input  logic [ADDRESSWIDTH-1:0] rdM,
  input  logic [ADDRESSWIDTH-1:0] rdW,
  input  logic                    regWriteM,
  input  logic                    regWriteW,
  input  logic                    memReqM,
  input  logic                    memReadyM,
  output logic                    stallF,
  output logic                    stallD,
  output logic                    stallE,
  output logic                    stallM,
  output logic                    flushD,
  output logic                    flushE,
  output logic [1:0]              forwardAE,
  output logic [1:0]              forwardBE,
  output logic                    memTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNTWIDTH-1:0]     stallCycles,
  output logic [CNTWIDTH-1:0]     flushCycles
`endif
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  if (CNTWIDTH < 1 || ADDRESSWIDTH < 1 || MEM_TIMEOUT < 1) begin : g_param_check
    $error("hazard_controller: parameters must be at least 1");
  end

  hazard_state_t    r_state, w_state_d;
  logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_d;
  logic             r_timeout;
  logic             w_mem_busy, w_load_use;
  fwd_sel_t         w_fwd_a, w_fwd_b;

  assign w_mem_busy = memReqM & ~memReadyM;
  assign w_load_use = memToRegE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  forwarding_unit #(.ADDRESSWIDTH(ADDRESSWIDTH)) u_fwd_a (
    .rsE      (rs1E),
    .rdM      (rdM),
    .rdW      (rdW),
    .regWriteM(regWriteM),
    .regWriteW(regWriteW),
    .fwd      (w_fwd_a)
  );

  forwarding_unit #(.ADDRESSWIDTH(ADDRESSWIDTH)) u_fwd_b (
    .rsE      (rs2E),
    .rdM      (rdM),
    .rdW      (rdW),
    .regWriteM(regWriteM),
    .regWriteW(regWriteW),
    .fwd      (w_fwd_b)
  );

  // A memory wait freezes everything; a held branch then applies once the wait ends.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    forwardAE = FWD_NONE;
    forwardBE = FWD_NONE;
    if (!reset) begin
      forwardAE = w_fwd_a;
      forwardBE = w_fwd_b;
      if (w_mem_busy) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end else if (takeBranchE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (w_load_use) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // waitCnt equals the number of consecutive busy cycles, saturating at MEM_TIMEOUT.
  always_comb begin
    w_state_d    = w_mem_busy ? MEMWAIT : RUN;
    w_wait_cnt_d = '0;
    if (w_mem_busy) begin
      if (r_state == RUN) begin
        w_wait_cnt_d = WaitW'(1);
      end else if (r_wait_cnt == WaitW'(MEM_TIMEOUT)) begin
        w_wait_cnt_d = r_wait_cnt;
      end else begin
        w_wait_cnt_d = r_wait_cnt + WaitW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_cnt_d;
      if (w_mem_busy && (w_wait_cnt_d == WaitW'(MEM_TIMEOUT))) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign memTimeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNTWIDTH-1:0] r_stall_cycles, r_flush_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (stallF && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + CNTWIDTH'(1);
      end
      if (flushE && !(&r_flush_cycles)) begin
        r_flush_cycles <= r_flush_cycles + CNTWIDTH'(1);
      end
    end
  end

  assign stallCycles = r_stall_cycles;
  assign flushCycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: stimulus queues expected outputs, a monitor checks them.
module tb_hazard_controller;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic          memToRegE, takeBranchE, regWriteM, regWriteW, memReqM, memReadyM;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, memTimeout;
  logic [1:0]    forwardAE, forwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stallCycles, flushCycles;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.ADDRESSWIDTH(AW), .MEM_TIMEOUT(15), .CNTWIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rs1E       (rs1E),
    .rs2E       (rs2E),
    .rdE        (rdE),
    .memToRegE  (memToRegE),
    .takeBranchE(takeBranchE),
    .rdM        (rdM),
    .rdW        (rdW),
    .regWriteM  (regWriteM),
    .regWriteW  (regWriteW),
    .memReqM    (memReqM),
    .memReadyM  (memReadyM),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .stallM     (stallM),
    .flushD     (flushD),
    .flushE     (flushE),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE),
    .memTimeout (memTimeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stallCycles(stallCycles),
    .flushCycles(flushCycles)
`endif
  );

  typedef struct packed {
    logic          reset;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          memToRegE, takeBranchE, regWriteM, regWriteW, memReqM, memReadyM;
  } in_t;

  typedef struct {
    logic [3:0] stl;  // {F, D, E, M}
    logic [1:0] fl;   // {D, E}
    logic [1:0] fa;
    logic [1:0] fb;
    logic       tmo;
    int         sc;   // expected stallCycles, -1 when not checked
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic apply(input in_t v);
    reset       = v.reset;
    rs1D        = v.rs1D;
    rs2D        = v.rs2D;
    rs1E        = v.rs1E;
    rs2E        = v.rs2E;
    rdE         = v.rdE;
    rdM         = v.rdM;
    rdW         = v.rdW;
    memToRegE   = v.memToRegE;
    takeBranchE = v.takeBranchE;
    regWriteM   = v.regWriteM;
    regWriteW   = v.regWriteW;
    memReqM     = v.memReqM;
    memReadyM   = v.memReadyM;
  endtask

  task automatic step(input in_t v, input logic [3:0] stl, input logic [1:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic tmo,
                      input int sc, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    apply(v);
    e.stl = stl; e.fl = fl; e.fa = fa; e.fb = fb; e.tmo = tmo; e.sc = sc; e.name = name;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({stallF, stallD, stallE, stallM} !== e.stl || {flushD, flushE} !== e.fl ||
          forwardAE !== e.fa || forwardBE !== e.fb || memTimeout !== e.tmo) begin
        errors++;
        $display("FAIL %s: got stall=%b flush=%b fa=%b fb=%b tmo=%b, want stall=%b flush=%b fa=%b fb=%b tmo=%b",
                 e.name, {stallF, stallD, stallE, stallM}, {flushD, flushE}, forwardAE,
                 forwardBE, memTimeout, e.stl, e.fl, e.fa, e.fb, e.tmo);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e.sc >= 0) begin
        checks++;
        if (stallCycles !== CW'(e.sc)) begin
          errors++;
          $display("FAIL %s_stallCycles: got %0d want %0d", e.name, stallCycles, e.sc);
        end
      end
`endif
    end
  end

  in_t v;

  initial begin
    v = '0;
    v.reset = 1'b1;
    apply(v);
    @(posedge clk);

    // Reset overrides hazards and forwards
    v = '0; v.reset = 1'b1; v.memToRegE = 1'b1; v.rdE = 4'd3; v.rs1D = 4'd3;
    v.memReqM = 1'b1; v.rdM = 4'd7; v.rs1E = 4'd7; v.regWriteM = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, -1, "reset_hold");
    v = '0;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, -1, "idle");

    // Load-use then bubble
    v = '0; v.memToRegE = 1'b1; v.rdE = 4'd3; v.rs1D = 4'd3;
    step(v, 4'b1100, 2'b01, 2'b00, 2'b00, 1'b0, -1, "load_use_rs1");
    v.memToRegE = 1'b0;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, -1, "load_use_bubble");
    v = '0; v.memToRegE = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, -1, "load_use_r0");
    v = '0; v.memToRegE = 1'b1; v.rdE = 4'd5; v.rs2D = 4'd5;
    step(v, 4'b1100, 2'b01, 2'b00, 2'b00, 1'b0, -1, "load_use_rs2");
    v.takeBranchE = 1'b1;
    step(v, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0, -1, "branch_over_load_use");

    // Forwarding priority and r0
    v = '0; v.rdM = 4'd7; v.rdW = 4'd7; v.rs1E = 4'd7; v.regWriteM = 1'b1; v.regWriteW = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, -1, "fwd_a_mem_wins");
    v.regWriteM = 1'b0;
    step(v, 4'b0000, 2'b00, 2'b01, 2'b00, 1'b0, -1, "fwd_a_wb");
    v = '0; v.rdW = 4'd9; v.rs2E = 4'd9; v.regWriteW = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b01, 1'b0, -1, "fwd_b_wb");
    v.rdM = 4'd9; v.regWriteM = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b10, 1'b0, -1, "fwd_b_mem");
    v = '0; v.regWriteM = 1'b1; v.regWriteW = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, -1, "fwd_r0");

    // Four-cycle memory wait, counters cleared first
    v = '0; v.reset = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, -1, "reset_before_wait");
    v = '0; v.memReqM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(v, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, -1, "mem_wait");
    end
    v.memReadyM = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 4, "mem_ready");

    // Branch held across a wait applies when the wait ends
    v = '0; v.memReqM = 1'b1; v.takeBranchE = 1'b1;
    step(v, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, -1, "branch_during_wait");
    v.memReadyM = 1'b1;
    step(v, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0, -1, "branch_after_wait");

    // Watchdog: flag visible after the 15th busy edge, sticky until reset
    v = '0; v.memReqM = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(v, 4'b1111, 2'b00, 2'b00, 2'b00, (k == 16), -1, "timeout_wait");
    end
    v = '0;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, -1, "timeout_sticky");
    v.reset = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, -1, "timeout_reset_cycle");
    v = '0;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, -1, "timeout_cleared");

    // Reset during a wait abandons it silently
    v = '0; v.memReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(v, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, -1, "wait_before_reset");
    end
    v.reset = 1'b1;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, -1, "reset_in_wait");
    v = '0;
    step(v, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, -1, "after_reset_in_wait");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have parameter ADDRESSWIDTH, default 4: register-address width (16 registers).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15: maximum memory-wait cycles before the error flag is raised.
REQ-003 The block SHALL have parameter CNTWIDTH, default 16: width of the performance counters.
REQ-004 The block SHALL have these ports; the clock is clk and the reset is reset, synchronous and active-high:
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 rs1D, rs2D  in  ADDRESSWIDTH  Decode source registers
 rs1E, rs2E, rdE  in  ADDRESSWIDTH  Execute source and destination registers
 memToRegE  in  1  Execute instruction is a load
 takeBranchE  in  1  branch resolved taken in Execute
 rdM, rdW  in  ADDRESSWIDTH  Memory and Writeback destination registers
 regWriteM, regWriteW  in  1  Memory and Writeback write enables
 memReqM  in  1  data-memory access active in Memory stage
 memReadyM  in  1  data memory completes the access this cycle
 stallF, stallD, stallE, stallM  out  1  stage hold enables
 flushD, flushE  out  1  stage bubble inserts
 forwardAE, forwardBE  out  2  Execute operand bypass selects
 memTimeout  out  1  sticky watchdog error

Function
REQ-005 Register r0 SHALL be hardwired zero and SHALL never cause a hazard or a forward.
REQ-006 memBusy SHALL be defined as memReqM & ~memReadyM, combinational.
REQ-007 When memBusy=1: stallF=stallD=stallE=stallM=1, flushD=flushE=0, in the same cycle, including the first wait cycle.
REQ-008 Load-use: when memToRegE=1, rdE!=0, (rdE==rs1D or rdE==rs2D) and memBusy=0: stallF=stallD=1, flushE=1 for exactly one cycle.
REQ-009 Branch: when takeBranchE=1 and memBusy=0: flushD=flushE=1 and stallF=stallD=0, overriding load-use.
REQ-010 A branch that occurs during memBusy SHALL be applied in the first cycle memBusy drops; takeBranchE is held by the frozen Execute stage.
REQ-011 forwardAE SHALL be 2'b10 if regWriteM and rdM!=0 and rdM==rs1E; else 2'b01 if regWriteW and rdW!=0 and rdW==rs1E; else 2'b00. The Memory-stage match SHALL win.
REQ-012 forwardBE SHALL follow the same rule using rs2E.
REQ-013 The FSM SHALL have states RUN and MEMWAIT.
REQ-014 FSM transition RUN->MEMWAIT SHALL occur on a clock edge with memBusy=1.
REQ-015 FSM transition MEMWAIT->RUN SHALL occur on a clock edge with memBusy=0.
REQ-016 waitCnt SHALL clear in RUN and increment each MEMWAIT cycle, saturating at MEM_TIMEOUT.
REQ-017 When waitCnt reaches MEM_TIMEOUT, memTimeout SHALL set and remain 1 until reset; stalls SHALL continue while memBusy=1.
REQ-018 With no hazards, all stall and flush outputs SHALL be 0.

Reset
REQ-019 On a clock edge with reset=1, the block SHALL set state=RUN, waitCnt=0, memTimeout=0 and all counters to 0.
REQ-020 While reset=1, all stall and flush outputs SHALL be 0, and forward selects SHALL be 2'b00.
REQ-021 Reset asserted during MEMWAIT SHALL abandon the wait without raising memTimeout.

Configuration
REQ-022 Macro HAZARD_PERF_CNT_EN, when defined, SHALL add outputs stallCycles and flushCycles, each CNTWIDTH wide.
REQ-023 stallCycles SHALL increment on each cycle with stallF=1; flushCycles SHALL increment on each cycle with flushE=1; both SHALL saturate at all-ones.
REQ-024 When HAZARD_PERF_CNT_EN is undefined, those ports and registers SHALL be absent, with otherwise identical behaviour.

Structure
REQ-025 Shared package cpu_pkg SHALL hold enum fwd_sel_t (FWD_NONE=00, FWD_WB=01, FWD_MEM=10) and enum hazard_state_t (RUN, MEMWAIT).
REQ-026 Forwarding logic SHALL live in sub-module forwarding_unit, instantiated once per operand.

Verification
REQ-027 The bench SHALL cover each scenario below:
 - Load-use: memToRegE=1, rdE=3, rs1D=3 -> one cycle stallF=stallD=flushE=1; next cycle all 0.
 - Load-use on r0: memToRegE=1, rdE=0, rs1D=0 -> no stall.
 - Branch plus load-use: takeBranchE=1 and load-use with rdE=5, rs2D=5 -> flushD=flushE=1, stallF=stallD=0.
 - Memory wait: memReqM=1, memReadyM=0 for 4 cycles, then 1 -> all four stalls high for 4 cycles, low on the ready cycle; memTimeout=0.
 - Timeout: memBusy held 16 cycles -> memTimeout=1 from cycle 15 until reset; reset -> memTimeout=0.
 - Forward priority: rdM=rdW=rs1E=7, regWriteM=regWriteW=1 -> forwardAE=10; regWriteM=0 -> 01.
 - With HAZARD_PERF_CNT_EN: after the 4-cycle memory wait, stallCycles=4.
